// File: rtl/comp_dict_pkg.sv
// Shared definitions for the field dictionaries that sit beside the
// compression controller: state encoding, per-field widths and the bit
// positions of each field inside an instruction word.
package comp_dict_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  // Key width and value width of each field dictionary
  localparam int FIELD1_IDX_SIZE = 3;
  localparam int FIELD2_IDX_SIZE = 8;
  localparam int FIELD3_IDX_SIZE = 5;
  localparam int FIELD1_SIZE     = 7;
  localparam int FIELD2_SIZE     = 15;
  localparam int FIELD3_SIZE     = 10;

  // Where each field lives inside a 32-bit instruction word
  localparam int FIELD1_LSB = 0;
  localparam int FIELD1_MSB = FIELD1_LSB + FIELD1_SIZE - 1;
  localparam int FIELD2_LSB = FIELD1_MSB + 1;
  localparam int FIELD2_MSB = FIELD2_LSB + FIELD2_SIZE - 1;
  localparam int FIELD3_LSB = FIELD2_MSB + 1;
  localparam int FIELD3_MSB = FIELD3_LSB + FIELD3_SIZE - 1;

endpackage

// File: rtl/comp_dict_prienc.sv
// Lowest-index priority encoder: turns a match vector into {any, index}.
// Index is 0 when nothing matches.
module comp_dict_prienc #(
  parameter int WIDTH = 8,
  parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic             any,
  output logic [IDXW-1:0]  idx
);

  // Scan from the top down so the lowest set bit wins
  always_comb begin
    any = |vec;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDXW'(i);
    end
  end

endmodule

// File: rtl/comp_dict_table.sv
// Bidirectional key<->value dictionary for one instruction field.
// Filled once through a valid/ready loader, then frozen and answers
// combinational forward (key->value) and reverse (value->key) lookups.
// Optional hit/miss statistics: define COMP_DICT_STATS_EN.
//
// Loader handshake: a beat transfers on any rising edge where
// load_valid && load_ready; load_val must be stable while load_valid is
// high. A beat whose value is already present is consumed but not stored,
// and load_err pulses for one cycle after it.
module comp_dict_table
  import comp_dict_pkg::*;
#(
  parameter int IDX_SIZE = FIELD1_IDX_SIZE,
  parameter int VAL_SIZE = FIELD1_SIZE
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [VAL_SIZE-1:0] load_val,
  input  logic                load_done,
  output logic                load_err,
  output logic [IDX_SIZE:0]   entry_count,
  output logic                table_active,
  input  logic [IDX_SIZE-1:0] key_lookup,
  output logic [VAL_SIZE-1:0] val_found,
  input  logic [VAL_SIZE-1:0] val_lookup,
  output logic                val_lookup_res,
  output logic [IDX_SIZE-1:0] key_found,
  output state_e              dbg_state
`ifdef COMP_DICT_STATS_EN
  ,
  input  logic                stats_sample,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  localparam int DEPTH = 1 << IDX_SIZE;
  localparam logic [IDX_SIZE:0] DEPTH_CNT = (IDX_SIZE + 1)'(DEPTH);
  localparam logic [IDX_SIZE:0] CNT_ONE   = (IDX_SIZE + 1)'(1);

  state_e                state_q, state_d;
  logic [DEPTH-1:0]      valid_q;
  logic [VAL_SIZE-1:0]   entry_q [DEPTH];
  logic [IDX_SIZE:0]     count_q;
  logic                  err_q;

  logic [DEPTH-1:0]      dup_vec, lkp_vec;
  logic                  dup_any, lkp_any;
  logic [IDX_SIZE-1:0]   dup_idx, lkp_idx;
  logic                  accept, dup_beat, write_en;
  logic [IDX_SIZE:0]     cnt_inc;

  // Ready only while resetn is released and there is room to store a beat
  assign load_ready = resetn &&
                      ((state_q == ST_EMPTY) ||
                       ((state_q == ST_LOAD) && (count_q < DEPTH_CNT)));

  assign accept   = load_valid && load_ready;
  assign dup_beat = accept && dup_any;
  assign write_en = accept && !dup_any && !flush;
  assign cnt_inc  = count_q + CNT_ONE;

  // Compare every stored entry against the incoming beat and the lookup value
  always_comb begin
    dup_vec = '0;
    lkp_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dup_vec[i] = valid_q[i] && (entry_q[i] == load_val);
      lkp_vec[i] = valid_q[i] && (entry_q[i] == val_lookup);
    end
  end

  comp_dict_prienc #(.WIDTH(DEPTH), .IDXW(IDX_SIZE)) u_dup_enc (
    .vec (dup_vec),
    .any (dup_any),
    .idx (dup_idx)
  );

  comp_dict_prienc #(.WIDTH(DEPTH), .IDXW(IDX_SIZE)) u_lkp_enc (
    .vec (lkp_vec),
    .any (lkp_any),
    .idx (lkp_idx)
  );

  // Next-state decode; flush overrides every other transition
  always_comb begin
    state_d      = state_q;
    table_active = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (load_done)     state_d = ST_ACTIVE;
        else if (write_en) state_d = (cnt_inc == DEPTH_CNT) ? ST_ACTIVE : ST_LOAD;
      end
      ST_LOAD: begin
        if (load_done || (write_en && (cnt_inc == DEPTH_CNT))) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        table_active = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  // State, valid bits, fill count and the duplicate-error pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      valid_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= dup_beat && !flush;
      if (flush) begin
        valid_q <= '0;
        count_q <= '0;
      end else if (write_en) begin
        valid_q[count_q[IDX_SIZE-1:0]] <= 1'b1;
        count_q                        <= cnt_inc;
      end
    end
  end

  // Entry storage is plain RAM; its contents are qualified by valid_q
  always_ff @(posedge clk) begin
    if (write_en) entry_q[count_q[IDX_SIZE-1:0]] <= load_val;
  end

  assign load_err       = err_q;
  assign entry_count    = count_q;
  assign dbg_state      = state_q;
  assign val_found      = (table_active && valid_q[key_lookup]) ? entry_q[key_lookup] : '0;
  assign val_lookup_res = table_active && lkp_any;
  assign key_found      = val_lookup_res ? lkp_idx : '0;

`ifdef COMP_DICT_STATS_EN
  // Saturating hit/miss counters for sampled lookups while active
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (flush) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (table_active && stats_sample) begin
      if (val_lookup_res) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_comp_dict_table.sv
// Directed bench for comp_dict_table (IDX_SIZE=3, VAL_SIZE=7).
// Stimulus pushes hand-computed expected output vectors into exp_q; a
// monitor on the falling edge pops and compares against the DUT.
// Observed vector: {load_ready, load_err, entry_count[3:0], table_active,
//                   val_found[6:0], val_lookup_res, key_found[2:0]}
module tb_comp_dict_table;
  import comp_dict_pkg::*;

  localparam int W = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       flush = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [6:0] load_val = '0;
  logic       load_done = 1'b0;
  logic       load_err;
  logic [3:0] entry_count;
  logic       table_active;
  logic [2:0] key_lookup = '0;
  logic [6:0] val_found;
  logic [6:0] val_lookup = '0;
  logic       val_lookup_res;
  logic [2:0] key_found;
  state_e     dbg_state;
`ifdef COMP_DICT_STATS_EN
  logic        stats_sample = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  comp_dict_table #(.IDX_SIZE(3), .VAL_SIZE(7)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_val       (load_val),
    .load_done      (load_done),
    .load_err       (load_err),
    .entry_count    (entry_count),
    .table_active   (table_active),
    .key_lookup     (key_lookup),
    .val_found      (val_found),
    .val_lookup     (val_lookup),
    .val_lookup_res (val_lookup_res),
    .key_found      (key_found),
    .dbg_state      (dbg_state)
`ifdef COMP_DICT_STATS_EN
    ,
    .stats_sample   (stats_sample),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  logic         smp_req = 1'b0;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] obs;

  assign obs = {load_ready, load_err, entry_count, table_active,
                val_found, val_lookup_res, key_found};

  function automatic logic [W-1:0] mk(input logic lr, input logic le,
                                      input logic [3:0] cnt, input logic ta,
                                      input logic [6:0] vf, input logic hit,
                                      input logic [2:0] kf);
    return {lr, le, cnt, ta, vf, hit, kf};
  endfunction

  // Monitor: pop and compare whenever the driver presents a sample point
  always @(negedge clk) begin
    if (smp_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: sample with empty expected queue, got %h", obs);
      end else begin
        logic [W-1:0] e;
        string        t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", t, obs, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation, sample at the next falling edge, return at posedge+1
  task automatic expect_now(input string tag, input logic [W-1:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    smp_req = 1'b1;
    @(negedge clk);
    #1;
    smp_req = 1'b0;
    tick();
  endtask

  task automatic beat(input logic [6:0] v);
    load_valid = 1'b1;
    load_val   = v;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic pulse_done();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  task automatic lookup(input logic [6:0] v, input logic [2:0] k);
    val_lookup = v;
    key_lookup = k;
  endtask

  task automatic cmp32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Guard against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    tick();
    tick();
    expect_now("reset_state", mk(0, 0, 4'd0, 0, 7'h00, 0, 3'd0));
    resetn = 1'b1;
    expect_now("empty_ready", mk(1, 0, 4'd0, 0, 7'h00, 0, 3'd0));

    // Basic fill: lookups are gated off until the table is frozen
    beat(7'h13);
    lookup(7'h13, 3'd0);
    expect_now("lookup_in_load", mk(1, 0, 4'd1, 0, 7'h00, 0, 3'd0));
    beat(7'h37);
    beat(7'h03);
    pulse_done();
    expect_now("active_hit_k0", mk(0, 0, 4'd3, 1, 7'h13, 1, 3'd0));
    lookup(7'h37, 3'd2);
    expect_now("active_hit_k1", mk(0, 0, 4'd3, 1, 7'h03, 1, 3'd1));
    lookup(7'h55, 3'd5);
    expect_now("active_miss", mk(0, 0, 4'd3, 1, 7'h00, 0, 3'd0));

    // Flush wins over a simultaneous beat
    flush      = 1'b1;
    load_valid = 1'b1;
    load_val   = 7'h44;
    tick();
    flush      = 1'b0;
    load_valid = 1'b0;
    lookup(7'h44, 3'd0);
    expect_now("flush_vs_beat", mk(1, 0, 4'd0, 0, 7'h00, 0, 3'd0));

    // Duplicate beat: one-cycle error pulse, count unchanged
    beat(7'h13);
    beat(7'h13);
    expect_now("dup_err_pulse", mk(1, 1, 4'd1, 0, 7'h00, 0, 3'd0));
    expect_now("dup_err_clear", mk(1, 0, 4'd1, 0, 7'h00, 0, 3'd0));
    pulse_flush();

    // Fill to DEPTH: automatic freeze after the eighth beat
    for (int i = 1; i <= 7; i++) beat(7'(i));
    expect_now("seven_entries", mk(1, 0, 4'd7, 0, 7'h00, 0, 3'd0));
    beat(7'h08);
    lookup(7'h05, 3'd7);
    expect_now("full_auto_active", mk(0, 0, 4'd8, 1, 7'h08, 1, 3'd4));
    beat(7'h09);
    expect_now("ninth_ignored", mk(0, 0, 4'd8, 1, 7'h08, 1, 3'd4));
    lookup(7'h09, 3'd7);
    expect_now("ninth_not_stored", mk(0, 0, 4'd8, 1, 7'h08, 0, 3'd0));
    lookup(7'h01, 3'd0);
    expect_now("full_first_entry", mk(0, 0, 4'd8, 1, 7'h01, 1, 3'd0));

    // load_done straight from EMPTY: active with nothing in it
    pulse_flush();
    pulse_done();
    lookup(7'h00, 3'd0);
    expect_now("done_from_empty", mk(0, 0, 4'd0, 1, 7'h00, 0, 3'd0));

    // Beat and load_done together: beat is kept
    pulse_flush();
    load_valid = 1'b1;
    load_val   = 7'h7F;
    load_done  = 1'b1;
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
    lookup(7'h7F, 3'd0);
    expect_now("beat_with_done", mk(0, 0, 4'd1, 1, 7'h7F, 1, 3'd0));

    // Asynchronous reset in the middle of a load
    pulse_flush();
    beat(7'h21);
    beat(7'h22);
    lookup(7'h21, 3'd1);
    expect_now("mid_load", mk(1, 0, 4'd2, 0, 7'h00, 0, 3'd0));
    resetn = 1'b0;
    expect_now("async_reset", mk(0, 0, 4'd0, 0, 7'h00, 0, 3'd0));
    resetn = 1'b1;
    expect_now("after_reset", mk(1, 0, 4'd0, 0, 7'h00, 0, 3'd0));

`ifdef COMP_DICT_STATS_EN
    beat(7'h13);
    beat(7'h37);
    beat(7'h03);
    pulse_done();
    stats_sample = 1'b1;
    lookup(7'h13, 3'd0); tick();
    lookup(7'h37, 3'd0); tick();
    lookup(7'h03, 3'd0); tick();
    lookup(7'h13, 3'd0); tick();
    lookup(7'h37, 3'd0); tick();
    lookup(7'h55, 3'd0); tick();
    lookup(7'h66, 3'd0); tick();
    stats_sample = 1'b0;
    cmp32("hit_count", hit_count, 32'd5);
    cmp32("miss_count", miss_count, 32'd2);
    pulse_flush();
    cmp32("hit_count_flush", hit_count, 32'd0);
    cmp32("miss_count_flush", miss_count, 32'd0);
`endif

    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
